// File: rtl/serial_pkg.sv
// ============================================================================
//  serial_pkg : shared state encodings, sync marker and error codes
//  Rev 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t ADDR    = 3'd1;
    localparam state_t LEN     = 3'd2;
    localparam state_t PAYLOAD = 3'd3;
    localparam state_t CHK     = 3'd4;
    localparam state_t EMIT    = 3'd5;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Codes shared with the response encoder that reports errors upstream
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/serial_pkt_buf.sv
// ============================================================================
//  serial_pkt_buf : payload store, one write port, asynchronous read port
//  Rev 1.0
// ============================================================================
`default_nettype none

module serial_pkt_buf #(
    parameter int MAX_LEN = 8,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [7:0]    wr_byte,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_byte
);

    logic [7:0] mem_q [0:MAX_LEN-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_byte;
        end
    end

    assign rd_byte = mem_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/serial_cmd_decoder.sv
// ============================================================================
//  serial_cmd_decoder : parses SYNC/ADDR/LEN/PAYLOAD/CHK frames into writes
//  Rev 1.0
// ============================================================================
`default_nettype none

module serial_cmd_decoder
    import serial_pkg::*;
#(
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CLK = 65104,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       pkt_done,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       rx_drop
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CLK - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    state_t        state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    acc_q, acc_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_to_q, err_to_d;
    logic          drop_q, drop_d;

    logic          buf_we;
    logic [7:0]    buf_rd;
    logic          last_idx;

    assign last_idx = (idx_q == len_q - IDX_ONE);

    serial_pkt_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (idx_q[AW-1:0]),
        .wr_byte (rx_data),
        .rd_idx  (idx_q[AW-1:0]),
        .rd_byte (buf_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        acc_d     = acc_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = '0;
        done_d    = 1'b0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        drop_d    = 1'b0;
        buf_we    = 1'b0;

        // Inter-byte watchdog; a byte in the expiry cycle keeps the packet alive
        if ((state_q == ADDR) || (state_q == LEN) ||
            (state_q == PAYLOAD) || (state_q == CHK)) begin
            if (!rx_valid) begin
                if (cnt_q == CNT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                idx_d = '0;
                acc_d = '0;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    base_d  = rx_data;
                    acc_d   = rx_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        len_d   = rx_data[IW-1:0];
                        acc_d   = acc_q ^ rx_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    acc_d  = acc_q ^ rx_data;
                    idx_d  = idx_q + IDX_ONE;
                    if (last_idx) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            EMIT: begin
                drop_d = rx_valid;
                if (wr_ready) begin
                    if (last_idx) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_valid    = (state_q == EMIT);
        wr_addr     = wr_valid ? (base_q + 8'(idx_q)) : 8'h00;
        wr_data     = wr_valid ? buf_rd : 8'h00;
        pkt_done    = done_q;
        err_chk     = err_chk_q;
        err_len     = err_len_q;
        err_timeout = err_to_q;
        rx_drop     = drop_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_cmd_decoder.sv
// ============================================================================
//  tb_serial_cmd_decoder : directed frames, queued expectations, monitor check
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_cmd_decoder;

    localparam int EV_DONE = 0;
    localparam int EV_CHK  = 1;
    localparam int EV_LEN  = 2;
    localparam int EV_TO   = 3;
    localparam int EV_DROP = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       pkt_done;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       rx_drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_hs_cyc = -10;

    logic [15:0] exp_beats [$];
    int          exp_evts  [$];

    logic        bp_mode = 1'b0;
    int          stall   = 0;
    logic        stalled_prev = 1'b0;
    logic [7:0]  held_addr, held_data;

    serial_cmd_decoder #(
        .MAX_LEN     (8),
        .TIMEOUT_CLK (100),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .pkt_done    (pkt_done),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .rx_drop     (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Sink: always ready, or five stall cycles ahead of every beat
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                wr_ready = 1'b1;
                stall    = 0;
            end else if (wr_valid && stall < 5) begin
                wr_ready = 1'b0;
                stall++;
            end else begin
                wr_ready = 1'b1;
                stall    = 0;
            end
        end
    end

    task automatic chk_evt(input int kind, input string name);
        int got;
        checks++;
        if (exp_evts.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse at cycle %0d, none required", name, cyc);
        end else begin
            got = exp_evts.pop_front();
            if (got != kind) begin
                errors++;
                $display("FAIL %s: pulse kind %0d seen, required kind %0d", name, kind, got);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                checks++;
                if (!wr_valid || wr_addr != held_addr || wr_data != held_data) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b addr=%h data=%h, required v=1 addr=%h data=%h",
                             wr_valid, wr_addr, wr_data, held_addr, held_data);
                end
            end
            if (wr_valid && wr_ready) begin
                checks++;
                if (exp_beats.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat addr=%h data=%h", wr_addr, wr_data);
                end else begin
                    logic [15:0] e;
                    e = exp_beats.pop_front();
                    if ({wr_addr, wr_data} != e) begin
                        errors++;
                        $display("FAIL beat: addr/data %h/%h, required %h/%h",
                                 wr_addr, wr_data, e[15:8], e[7:0]);
                    end
                end
                last_hs_cyc = cyc;
            end
            stalled_prev = wr_valid && !wr_ready;
            held_addr    = wr_addr;
            held_data    = wr_data;
            if (pkt_done) begin
                chk_evt(EV_DONE, "pkt_done");
                checks++;
                if (cyc != last_hs_cyc + 1) begin
                    errors++;
                    $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, last_hs_cyc + 1);
                end
            end
            if (err_chk)     chk_evt(EV_CHK,  "err_chk");
            if (err_len)     chk_evt(EV_LEN,  "err_len");
            if (err_timeout) chk_evt(EV_TO,   "err_timeout");
            if (rx_drop)     chk_evt(EV_DROP, "rx_drop");
        end
    end

    task automatic sb(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] d);
        exp_beats.push_back({a, d});
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({wr_valid, wr_addr, wr_data, pkt_done, err_chk, err_len, err_timeout, rx_drop} != '0) begin
            errors++;
            $display("FAIL %s: outputs v=%b a=%h d=%h done=%b chk=%b len=%b to=%b drop=%b, required all 0",
                     name, wr_valid, wr_addr, wr_data, pkt_done, err_chk, err_len, err_timeout, rx_drop);
        end
    endtask

    // 10^03^11^22^33 = 13
    task automatic good_pkt;
        beat(8'h10, 8'h11); beat(8'h11, 8'h22); beat(8'h12, 8'h33);
        sb(8'hA5); sb(8'h10); sb(8'h03); sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h13);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check_quiet("reset_state");
        rst_n = 1'b1;
        idle(2);

        good_pkt();
        exp_evts.push_back(EV_DONE);
        idle(10);

        bp_mode = 1'b1;
        good_pkt();
        idle(2);
        exp_evts.push_back(EV_DROP);
        sb(8'h5A);
        exp_evts.push_back(EV_DONE);
        idle(40);
        bp_mode = 1'b0;
        idle(2);

        // 10^01^55 = 44, so 00 is wrong
        exp_evts.push_back(EV_CHK);
        sb(8'hA5); sb(8'h10); sb(8'h01); sb(8'h55); sb(8'h00);
        idle(5);
        good_pkt();
        exp_evts.push_back(EV_DONE);
        idle(10);

        sb(8'h00); sb(8'hFF);
        exp_evts.push_back(EV_LEN);
        sb(8'hA5); sb(8'h20); sb(8'h00);
        idle(3);
        exp_evts.push_back(EV_LEN);
        sb(8'hA5); sb(8'h20); sb(8'h09);
        idle(5);

        // Byte at count 99 survives; silence afterwards then expires once
        sb(8'hA5); sb(8'h30); sb(8'h02); sb(8'h7E);
        idle(99);
        sb(8'h7F);
        exp_evts.push_back(EV_TO);
        idle(100);
        idle(10);

        // FE^03^01^02^03 = FD
        beat(8'hFE, 8'h01); beat(8'hFF, 8'h02); beat(8'h00, 8'h03);
        exp_evts.push_back(EV_DONE);
        sb(8'hA5); sb(8'hFE); sb(8'h03); sb(8'h01); sb(8'h02); sb(8'h03); sb(8'hFD);
        idle(10);

        sb(8'hA5); sb(8'h40); sb(8'h04); sb(8'h01); sb(8'h02);
        rst_n = 1'b0;
        idle(1);
        check_quiet("mid_packet_reset");
        rst_n = 1'b1;
        idle(1);
        check_quiet("after_reset");
        idle(150);
        good_pkt();
        exp_evts.push_back(EV_DONE);
        idle(20);

        checks++;
        if (exp_beats.size() != 0) begin
            errors++;
            $display("FAIL beats_left: %0d beats never seen, required 0", exp_beats.size());
        end
        checks++;
        if (exp_evts.size() != 0) begin
            errors++;
            $display("FAIL pulses_left: %0d pulses never seen, required 0", exp_evts.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
